// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer SRAM path: geometry constants, the
// host-side sequencer state encoding, and the packed-pixel helpers used by
// both the arbiter and the display pixel fetcher.
//
// Contents:
//   ADDR_W / PIX_W / SEL_W / WORD_W   framebuffer geometry
//   host_state_e                      host sequencer states
//   pix_extract(word, sel)            return pixel 'sel' of a packed word
//   pix_insert(word, sel, pix)        return 'word' with pixel 'sel' replaced
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package fb_pkg;

    localparam int ADDR_W = 9;
    localparam int PIX_W  = 4;
    localparam int SEL_W  = 3;
    localparam int WORD_W = PIX_W * (2 ** SEL_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HCAP = 2'd1,
        S_HWR  = 2'd2,
        S_HACK = 2'd3
    } host_state_e;

    // Pixel k lives in bits [PIX_W*k + PIX_W-1 : PIX_W*k].
    function automatic logic [PIX_W-1:0] pix_extract(
        input logic [WORD_W-1:0] word,
        input logic [SEL_W-1:0]  sel
    );
        return word[PIX_W*int'(sel) +: PIX_W];
    endfunction

    function automatic logic [WORD_W-1:0] pix_insert(
        input logic [WORD_W-1:0] word,
        input logic [SEL_W-1:0]  sel,
        input logic [PIX_W-1:0]  pix
    );
        logic [WORD_W-1:0] merged;
        merged = word;
        merged[PIX_W*int'(sel) +: PIX_W] = pix;
        return merged;
    endfunction

endpackage

// File: rtl/fb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// fb_mem_arbiter
// Shares the single-port framebuffer SRAM between the display pixel fetcher
// (absolute priority, one-cycle read issue, never stalled) and the host port
// (pixel reads, and pixel writes done as read-modify-write of the packed
// word).
//
// Ports:
//   clk_25, rst                       clock, async active-high reset
//   disp_req/addr/sel                 display read request (any cycle)
//   disp_valid/disp_pixel             display pixel, one cycle after request
//   host_req/we/addr/sel/wdata        host request, held until host_ack
//   host_ack/host_rdata               completion pulse, read pixel
//   mem_en/we/addr/wdata, mem_rdata   SRAM port (read data registered,
//                                     valid the cycle after a read strobe)
//   busy                              host transaction in progress
//
// The geometry parameters must match fb_pkg; the pixel helpers are sized
// from the package constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fb_mem_arbiter #(
    parameter int ADDR_W = fb_pkg::ADDR_W,
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int SEL_W  = fb_pkg::SEL_W,
    parameter int WORD_W = PIX_W * (2 ** SEL_W)
) (
    input  logic              clk_25,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    input  logic [SEL_W-1:0]  disp_sel,
    output logic              disp_valid,
    output logic [PIX_W-1:0]  disp_pixel,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [SEL_W-1:0]  host_sel,
    input  logic [PIX_W-1:0]  host_wdata,
    output logic              host_ack,
    output logic [PIX_W-1:0]  host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);

    import fb_pkg::*;

    host_state_e       state_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [SEL_W-1:0]  sel_q;
    logic [PIX_W-1:0]  wdata_q;
    logic [WORD_W-1:0] buf_q;
    logic [PIX_W-1:0]  rdata_q;
    logic              ack_q;
    logic              disp_valid_q;
    logic [SEL_W-1:0]  disp_sel_q;

    logic disp_go;
    logic host_issue;
    logic host_write;

    // The port strobes are combinational (the display must issue in the
    // cycle it asks), so they are masked while reset is asserted to keep
    // every output at zero for the whole reset window.
    assign disp_go    = disp_req && !rst;
    assign host_issue = !rst && (state_q == S_IDLE) && host_req && !disp_req;
    assign host_write = !rst && (state_q == S_HWR) && !disp_req;

    // Port mux: display first, then the host read issue, then the host write.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_go) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (host_issue) begin
            mem_en   = 1'b1;
            mem_addr = host_addr;
        end else if (host_write) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = pix_insert(buf_q, sel_q, wdata_q);
        end
    end

    // Host sequencer. host_ack is registered: it is raised on the edge that
    // enters S_HACK, so it is high exactly for the S_HACK cycle.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (host_issue) begin
                        we_q    <= host_we;
                        addr_q  <= host_addr;
                        sel_q   <= host_sel;
                        wdata_q <= host_wdata;
                        state_q <= S_HCAP;
                    end
                end
                S_HCAP: begin
                    // Read data for the host is on mem_rdata now; the port
                    // itself is free for the display this cycle.
                    buf_q <= mem_rdata;
                    if (we_q) begin
                        state_q <= S_HWR;
                    end else begin
                        rdata_q <= pix_extract(mem_rdata, sel_q);
                        ack_q   <= 1'b1;
                        state_q <= S_HACK;
                    end
                end
                S_HWR: begin
                    if (!disp_req) begin
                        ack_q   <= 1'b1;
                        state_q <= S_HACK;
                    end
                end
                S_HACK: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Display register stage: remember which pixel to pick out of the word
    // that the SRAM returns on the following cycle.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            disp_valid_q <= 1'b0;
            disp_sel_q   <= '0;
        end else begin
            disp_valid_q <= disp_req;
            if (disp_req) begin
                disp_sel_q <= disp_sel;
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_pixel = disp_valid_q ? pix_extract(mem_rdata, disp_sel_q) : '0;
    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    assign busy       = (state_q != S_IDLE);

endmodule
